// File: rtl/mult_hilo_unit_pkg.sv
// Shared definitions for the HI/LO multiply unit: read-select codes, FSM
// state encoding and the default operand width.
package mult_hilo_unit_pkg;

    localparam int DEFAULT_WIDTH = 32;

    localparam logic [1:0] SEL_ALU = 2'b00;
    localparam logic [1:0] SEL_HI  = 2'b01;
    localparam logic [1:0] SEL_LO  = 2'b10;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_RUN  = 2'd1;
    localparam state_t ST_DONE = 2'd2;

endpackage

// File: rtl/mult_datapath.sv
// Iterative unsigned shift-add multiplier datapath: operand, partial product and
// step counter. Radix-4 stepping (two multiplier bits per cycle) under MULT_RADIX4_EN.
module mult_datapath
    import mult_hilo_unit_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               step,
    input  logic [WIDTH-1:0]   src_a,
    input  logic [WIDTH-1:0]   src_b,
    output logic [2*WIDTH-1:0] prod_next,
    output logic               last
);

`ifdef MULT_RADIX4_EN
    localparam int STEPS = WIDTH / 2;
`else
    localparam int STEPS = WIDTH;
`endif
    localparam int CNT_W = $clog2(STEPS + 1);

    logic [WIDTH-1:0]   a_reg;
    logic [2*WIDTH-1:0] p_reg;
    logic [CNT_W-1:0]   cnt;

    // The multiplier occupies the low half of p_reg and is shifted out as the
    // accumulated upper half shifts in, so after the last step p_reg is the product.
`ifdef MULT_RADIX4_EN
    logic [WIDTH+1:0] addend;
    logic [WIDTH+1:0] sum;

    always_comb begin
        addend = '0;
        case (p_reg[1:0])
            2'b01:   addend = {2'b00, a_reg};
            2'b10:   addend = {1'b0, a_reg, 1'b0};
            2'b11:   addend = {2'b00, a_reg} + {1'b0, a_reg, 1'b0};
            default: addend = '0;
        endcase
    end

    assign sum       = {2'b00, p_reg[2*WIDTH-1:WIDTH]} + addend;
    assign prod_next = {sum, p_reg[WIDTH-1:2]};
`else
    logic [WIDTH:0] sum;

    assign sum       = {1'b0, p_reg[2*WIDTH-1:WIDTH]} + (p_reg[0] ? {1'b0, a_reg} : '0);
    assign prod_next = {sum, p_reg[WIDTH-1:1]};
`endif

    assign last = (cnt == CNT_W'(STEPS - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg <= '0;
            p_reg <= '0;
            cnt   <= '0;
        end else if (start) begin
            a_reg <= src_a;
            p_reg <= {{WIDTH{1'b0}}, src_b};
            cnt   <= '0;
        end else if (step) begin
            p_reg <= prod_next;
            cnt   <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/mult_hilo_unit.sv
// MIPS-style multu unit: IDLE/RUN/DONE control, architectural HI/LO registers
// and the EX-stage result mux. Optional radix-4 datapath via MULT_RADIX4_EN.
module mult_hilo_unit
    import mult_hilo_unit_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             multu,
    input  logic [1:0]       sel,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic [WIDTH-1:0] alu_result,
    output logic [WIDTH-1:0] dout,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             stall
);

    state_t             state;
    logic               start;
    logic               step;
    logic               last;
    logic [2*WIDTH-1:0] prod_next;

    // A new multiply may start from IDLE or straight out of DONE; RUN ignores multu.
    assign start = multu && (state != ST_RUN);
    assign step  = (state == ST_RUN);

    mult_datapath #(
        .WIDTH(WIDTH)
    ) u_datapath (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .step      (step),
        .src_a     (src_a),
        .src_b     (src_b),
        .prod_next (prod_next),
        .last      (last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            hi    <= '0;
            lo    <= '0;
        end else begin
            case (state)
                ST_RUN: begin
                    if (last) begin
                        state    <= ST_DONE;
                        {hi, lo} <= prod_next;
                    end
                end
                default: state <= multu ? ST_RUN : ST_IDLE;
            endcase
        end
    end

    assign busy  = (state == ST_RUN);
    assign done  = (state == ST_DONE);
    assign stall = busy && ((sel == SEL_HI) || (sel == SEL_LO) || multu);

    always_comb begin
        dout = alu_result;
        case (sel)
            SEL_HI:  dout = hi;
            SEL_LO:  dout = lo;
            default: dout = alu_result;
        endcase
    end

endmodule

// File: tb/tb_mult_hilo_unit.sv
// Directed bench for mult_hilo_unit: reset state, products, latency, stall/mux
// behaviour, mid-run reset, back-to-back restart and a random product sweep.
module tb_mult_hilo_unit;

    localparam int WIDTH = 32;
`ifdef MULT_RADIX4_EN
    localparam int LAT = WIDTH / 2;
`else
    localparam int LAT = WIDTH;
`endif

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             multu = 1'b0;
    logic [1:0]       sel = 2'b00;
    logic [WIDTH-1:0] src_a = '0;
    logic [WIDTH-1:0] src_b = '0;
    logic [WIDTH-1:0] alu_result = 32'h1234_5678;
    logic [WIDTH-1:0] dout;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy;
    logic             done;
    logic             stall;

    int n_cmp = 0;
    int n_bad = 0;

    mult_hilo_unit #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .multu      (multu),
        .sel        (sel),
        .src_a      (src_a),
        .src_b      (src_b),
        .alu_result (alu_result),
        .dout       (dout),
        .hi         (hi),
        .lo         (lo),
        .busy       (busy),
        .done       (done),
        .stall      (stall)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Present operands and hold multu for exactly one sampling edge; returns #1 after it.
    task automatic start_mult(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        @(negedge clk);
        src_a = a;
        src_b = b;
        multu = 1'b1;
        @(posedge clk);
        #1;
        multu = 1'b0;
    endtask

    // Counts rising edges until done is seen (bounded); returns #1 after that edge.
    task automatic wait_done(output int lat);
        lat = 0;
        while (done !== 1'b1 && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    int          lat;
    int          bad;
    int          pulses;
    logic [31:0] ra;
    logic [31:0] rb;
    logic [63:0] exp_p;

    initial begin
        // Reset state and pass-through mux with hi=lo=0
        #12;
        check_val("rst_busy", {63'd0, busy}, 64'd0);
        check_val("rst_done", {63'd0, done}, 64'd0);
        check_val("rst_hi", {32'd0, hi}, 64'd0);
        check_val("rst_lo", {32'd0, lo}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        sel = 2'b01;
        #1 check_val("post_rst_mfhi", {32'd0, dout}, 64'd0);
        sel = 2'b10;
        #1 check_val("post_rst_mflo", {32'd0, dout}, 64'd0);
        sel = 2'b00;
        #1 check_val("mux_alu00", {32'd0, dout}, 64'h1234_5678);
        sel = 2'b11;
        #1 check_val("mux_alu11", {32'd0, dout}, 64'h1234_5678);
        sel = 2'b00;

        // 3 * 5
        start_mult(32'd3, 32'd5);
        check_val("busy_run", {63'd0, busy}, 64'd1);
        wait_done(lat);
        check_val("lat_3x5", 64'(lat), 64'(LAT));
        check_val("prod_3x5", {hi, lo}, 64'h0000_0000_0000_000F);
        @(posedge clk);
        #1 check_val("done_one_cycle", {63'd0, done}, 64'd0);

        // 0xFFFFFFFF squared; hi/lo must keep the old product while running
        start_mult(32'hFFFF_FFFF, 32'hFFFF_FFFF);
        repeat (LAT / 2) @(posedge clk);
        #1 check_val("hold_lo_run", {32'd0, lo}, 64'h0000_000F);
        wait_done(lat);
        check_val("prod_max", {hi, lo}, 64'hFFFF_FFFE_0000_0001);

        // A few more directed products
        start_mult(32'h1234_5678, 32'd0);
        wait_done(lat);
        check_val("prod_zero", {hi, lo}, 64'd0);
        start_mult(32'hFFFF_FFFF, 32'd2);
        wait_done(lat);
        check_val("prod_x2", {hi, lo}, 64'h0000_0001_FFFF_FFFE);
        start_mult(32'h0001_0000, 32'h0001_0000);
        wait_done(lat);
        check_val("prod_2p32", {hi, lo}, 64'h0000_0001_0000_0000);

        // multu during RUN is ignored but requests a stall
        start_mult(32'hDEAD_BEEF, 32'd1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        src_a = 32'd5;
        src_b = 32'd5;
        multu = 1'b1;
        #1 check_val("stall_multu", {63'd0, stall}, 64'd1);
        @(posedge clk);
        #1 multu = 1'b0;
        wait_done(lat);
        check_val("lat_ignore", 64'(lat + 4), 64'(LAT));
        check_val("prod_ignore", {hi, lo}, 64'h0000_0000_DEAD_BEEF);

        // mfhi stalls during RUN with the old hi, then reads the new hi in DONE
        start_mult(32'hAA00_0000, 32'h0000_0100);
        wait_done(lat);
        check_val("prev_hi_aa", {32'd0, hi}, 64'h0000_00AA);
        start_mult(32'h8000_0000, 32'd6);
        repeat (4) @(posedge clk);
        #1 sel = 2'b01;
        bad = 0;
        lat = 0;
        while (done !== 1'b1 && lat < 200) begin
            #1;
            if (stall !== 1'b1 || dout !== 32'hAA) bad++;
            @(posedge clk);
            #1;
            lat++;
        end
        check_val("mfhi_hold", 64'(bad), 64'd0);
        check_val("mfhi_lat", 64'(lat + 4), 64'(LAT));
        check_val("mfhi_done_stall", {63'd0, stall}, 64'd0);
        check_val("mfhi_done_dout", {32'd0, dout}, 64'h0000_0003);
        sel = 2'b00;

        // Reset in the middle of a multiply
        start_mult(32'd9, 32'd9);
        repeat (9) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_val("midrst_busy", {63'd0, busy}, 64'd0);
        check_val("midrst_hilo", {hi, lo}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        repeat (LAT + 8) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) pulses++;
        end
        check_val("midrst_no_done", 64'(pulses), 64'd0);
        check_val("midrst_hilo_kept", {hi, lo}, 64'd0);
        start_mult(32'd7, 32'd6);
        wait_done(lat);
        check_val("prod_7x6", {hi, lo}, 64'd42);

        // Back-to-back: multu held in the DONE cycle restarts immediately
        start_mult(32'd10, 32'd10);
        wait_done(lat);
        check_val("b2b_first", {hi, lo}, 64'd100);
        src_a = 32'd2;
        src_b = 32'h8000_0000;
        multu = 1'b1;
        @(posedge clk);
        #1 multu = 1'b0;
        check_val("b2b_busy", {63'd0, busy}, 64'd1);
        wait_done(lat);
        check_val("b2b_lat", 64'(lat), 64'(LAT));
        check_val("b2b_prod", {hi, lo}, 64'h0000_0001_0000_0000);

        // Random sweep against a full-width reference product
        bad = 0;
        for (int i = 0; i < 1000; i++) begin
            ra = $urandom;
            rb = $urandom;
            exp_p = 64'(ra) * 64'(rb);
            start_mult(ra, rb);
            wait_done(lat);
            if ({hi, lo} !== exp_p || lat != LAT) begin
                bad++;
                if (bad <= 5)
                    $display("random pair %0d: 0x%0h * 0x%0h got 0x%0h lat %0d", i, ra, rb, {hi, lo}, lat);
            end
        end
        check_val("random_sweep", 64'(bad), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
